// File: rtl/wbm_spi_ctrl_pkg.sv
// Shared definitions for the SPI-to-Wishbone command sequencer: opcodes,
// FSM state encoding and status-byte layout.
package wbm_spi_ctrl_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_READ   = 8'h01;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;

  localparam int STAT_ERR_BIT = 0;
  localparam int STAT_OVR_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  function automatic logic [7:0] status_byte(input logic ovr, input logic err);
    logic [7:0] b;
    b               = '0;
    b[STAT_ERR_BIT] = err;
    b[STAT_OVR_BIT] = ovr;
    return b;
  endfunction

endpackage

// File: rtl/wbm_spi_ctrl_timeout.sv
// Bus-cycle watchdog: counts cycles while enabled and flags the last
// permitted cycle so the sequencer can abort on the following edge.
module wbm_spi_ctrl_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            W    = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted during the TIMEOUT-th bus cycle; cnt_q starts at 0 on BUS entry.
  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/wbm_spi_ctrl.sv
// Parses opcode/address/data byte frames from the SPI receive path, runs one
// classic Wishbone master cycle per frame and returns read/status bytes.
module wbm_spi_ctrl
  import wbm_spi_ctrl_pkg::*;
#(
  parameter int         TIMEOUT  = 255,
  parameter logic [7:0] ERR_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_stb,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  output logic       wbm_we_o,
  output logic [7:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  input  logic       wbm_ack_i,
  output logic       err,
  output logic       overrun,
  output state_e     dbg_state_o
);

  // tx handshake: tx_valid stays high with tx_data frozen until a cycle in
  // which tx_ready is also high; that edge completes the byte transfer.

  state_e     state_q;
  logic       is_write_q;
  logic       cyc_q;
  logic       we_q;
  logic [7:0] adr_q;
  logic [7:0] dat_q;
  logic       tx_valid_q;
  logic [7:0] tx_data_q;
  logic       err_q;
  logic       overrun_q;
  logic       expired;

  wbm_spi_ctrl_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q != ST_BUS),
    .en_i      (state_q == ST_BUS),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      is_write_q <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_stb) begin
            case (rx_data)
              OP_NOP: ;
              OP_READ, OP_WRITE: begin
                is_write_q <= (rx_data == OP_WRITE);
                state_q    <= ST_ADDR;
              end
              OP_STATUS: begin
                // Snapshot is taken before the clear; nothing can set a flag in IDLE.
                tx_data_q  <= status_byte(overrun_q, err_q);
                tx_valid_q <= 1'b1;
                err_q      <= 1'b0;
                overrun_q  <= 1'b0;
                state_q    <= ST_RESP;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        ST_ADDR: begin
          if (rx_stb) begin
            adr_q <= rx_data;
            if (is_write_q) begin
              state_q <= ST_DATA;
            end else begin
              cyc_q   <= 1'b1;
              we_q    <= 1'b0;
              state_q <= ST_BUS;
            end
          end
        end
        ST_DATA: begin
          if (rx_stb) begin
            dat_q   <= rx_data;
            cyc_q   <= 1'b1;
            we_q    <= 1'b1;
            state_q <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (rx_stb) begin
            overrun_q <= 1'b1;
          end
          // Ack has priority over a simultaneous expiry.
          if (wbm_ack_i) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            if (is_write_q) begin
              state_q <= ST_IDLE;
            end else begin
              tx_data_q  <= wbm_dat_i;
              tx_valid_q <= 1'b1;
              state_q    <= ST_RESP;
            end
          end else if (expired) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            err_q <= 1'b1;
            if (is_write_q) begin
              state_q <= ST_IDLE;
            end else begin
              tx_data_q  <= ERR_BYTE;
              tx_valid_q <= 1'b1;
              state_q    <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (rx_stb) begin
            overrun_q <= 1'b1;
          end
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign err         = err_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wbm_spi_ctrl.sv
// Directed bench for wbm_spi_ctrl: frame-level model feeding expected queues,
// a per-cycle monitor checking bus/tx behaviour, and a scripted slave.
module tb_wbm_spi_ctrl;
  import wbm_spi_ctrl_pkg::*;

  localparam int         TO  = 4;
  localparam logic [7:0] ERR = 8'hFF;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       rx_stb = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [7:0] wbm_adr_o, wbm_dat_o;
  logic [7:0] wbm_dat_i;
  logic       wbm_ack_i;
  logic       err, overrun;
  state_e     dbg_state_o;

  wbm_spi_ctrl #(.TIMEOUT(TO), .ERR_BYTE(ERR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_stb      (rx_stb),
    .rx_data     (rx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .err         (err),
    .overrun     (overrun),
    .dbg_state_o (dbg_state_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: bus entries are {we, adr, dat, duration}
  logic [7:0]  exp_tx_q[$];
  logic [32:0] exp_bus_q[$];
  logic        err_m = 1'b0;
  logic        ovr_m = 1'b0;

  function automatic int bus_len(input int delay);
    if (delay >= 0 && delay < TO) return delay + 1;
    return TO;
  endfunction

  task automatic model_read(input logic [7:0] adr, input int delay, input logic [7:0] rdata);
    logic timed;
    timed = !(delay >= 0 && delay < TO);
    exp_bus_q.push_back({1'b0, adr, 8'h00, 16'(bus_len(delay))});
    exp_tx_q.push_back(timed ? ERR : rdata);
    if (timed) err_m = 1'b1;
  endtask

  task automatic model_write(input logic [7:0] adr, input logic [7:0] dat, input int delay);
    exp_bus_q.push_back({1'b1, adr, dat, 16'(bus_len(delay))});
    if (!(delay >= 0 && delay < TO)) err_m = 1'b1;
  endtask

  task automatic model_status();
    exp_tx_q.push_back(8'(2 * ovr_m + err_m));
    err_m = 1'b0;
    ovr_m = 1'b0;
  endtask

  // scripted slave: ack in bus cycle slave_delay+1, never when negative
  int         slave_delay = 0;
  logic [7:0] slave_rdata = 8'h00;
  int         bus_seen = 0;
  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (wbm_cyc_o) bus_seen++; else bus_seen = 0;
      wbm_ack_i = wbm_cyc_o && (slave_delay >= 0) && (bus_seen == slave_delay + 1);
      wbm_dat_i = wbm_ack_i ? slave_rdata : 8'h00;
    end
  end

  // per-cycle monitor / compare process
  int         mon_cnt = 0;
  logic [7:0] cap_adr;
  logic       cap_we;
  logic [7:0] cap_dat;
  int         last_dur = 0;
  logic [7:0] last_tx = 8'h00;
  logic       prev_valid = 1'b0;
  logic       prev_xfer = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) begin
      exp_tx_q.delete();
      exp_bus_q.delete();
      mon_cnt    = 0;
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      check("stb_eq_cyc", wbm_stb_o, wbm_cyc_o);
      if (wbm_cyc_o) begin
        if (mon_cnt == 0) begin
          cap_adr = wbm_adr_o; cap_we = wbm_we_o; cap_dat = wbm_dat_o;
        end else begin
          check("adr_stable", wbm_adr_o, cap_adr);
          check("we_stable", wbm_we_o, cap_we);
          check("dat_stable", wbm_dat_o, cap_dat);
        end
        mon_cnt++;
      end else if (mon_cnt != 0) begin
        last_dur = mon_cnt;
        check("bus_expected", exp_bus_q.size() > 0, 1);
        if (exp_bus_q.size() > 0) begin
          e = exp_bus_q.pop_front();
          check("bus_we", cap_we, e[32]);
          check("bus_adr", cap_adr, e[31:24]);
          if (e[32]) check("bus_dat", cap_dat, e[23:16]);
          check("bus_dur", mon_cnt, e[15:0]);
          check("tx_after_bus", tx_valid, !e[32]);
        end
        mon_cnt = 0;
      end
      if (prev_xfer) check("tx_valid_drop", tx_valid, 0);
      if (tx_valid && prev_valid && !prev_xfer) check("tx_data_stable", tx_data, prev_data);
      if (tx_valid && tx_ready) begin
        last_tx = tx_data;
        check("tx_expected", exp_tx_q.size() > 0, 1);
        if (exp_tx_q.size() > 0) check("tx_byte", tx_data, exp_tx_q.pop_front());
      end
      prev_valid = tx_valid;
      prev_data  = tx_data;
      prev_xfer  = tx_valid && tx_ready;
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_stb = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_stb = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] adr, input int delay, input logic [7:0] rdata);
    slave_delay = delay; slave_rdata = rdata;
    model_read(adr, delay, rdata);
    send_byte(8'h01);
    check("cyc_before_adr", wbm_cyc_o, 0);
    send_byte(adr);
    check("cyc_rise_rd", wbm_cyc_o, 1);
    check("we_rd", wbm_we_o, 0);
  endtask

  task automatic do_write(input logic [7:0] adr, input logic [7:0] dat, input int delay);
    slave_delay = delay;
    model_write(adr, dat, delay);
    send_byte(8'h02);
    send_byte(adr);
    check("cyc_before_dat", wbm_cyc_o, 0);
    send_byte(dat);
    check("cyc_rise_wr", wbm_cyc_o, 1);
    check("we_wr", wbm_we_o, 1);
  endtask

  task automatic do_status();
    model_status();
    send_byte(8'h03);
    check("status_valid", tx_valid, 1);
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (!wbm_cyc_o && !tx_valid && exp_tx_q.size() == 0 && exp_bus_q.size() == 0) break;
    end
    check("quiet_cyc", wbm_cyc_o, 0);
    check("quiet_tx", tx_valid, 0);
    check("quiet_txq", exp_tx_q.size(), 0);
    check("quiet_busq", exp_bus_q.size(), 0);
    check("err_model", err, err_m);
    check("ovr_model", overrun, ovr_m);
  endtask

  task automatic wait_tx_valid();
    for (int i = 0; i < 40; i++) begin
      if (tx_valid) break;
      @(posedge clk); #1;
    end
    check("wait_tx_valid", tx_valid, 1);
  endtask

  task automatic async_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_state", dbg_state_o, ST_IDLE);
    @(posedge clk); #3;
    rst_n = 1'b1;
    err_m = 1'b0;
    ovr_m = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_tx_valid0", tx_valid, 0);
    check("rst_tx_data0", tx_data, 8'h00);
    check("rst_cyc0", wbm_cyc_o, 0);
    check("rst_stb0", wbm_stb_o, 0);
    check("rst_we0", wbm_we_o, 0);
    check("rst_adr0", wbm_adr_o, 8'h00);
    check("rst_dat0", wbm_dat_o, 8'h00);
    check("rst_err0", err, 0);
    check("rst_ovr0", overrun, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // READ, ack after 2 waits; tx_ready already high
    tx_ready = 1'b1;
    do_read(8'h3C, 2, 8'hA5);
    wait_quiet();
    check("rd_dur_lit", last_dur, 3);
    check("rd_byte_lit", last_tx, 8'hA5);
    check("rd_err_lit", err, 0);

    // WRITE, zero-wait ack
    do_write(8'h10, 8'h5A, 0);
    wait_quiet();
    check("wr_dur_lit", last_dur, 1);
    check("wr_adr_lit", wbm_adr_o, 8'h10);
    check("wr_dat_lit", wbm_dat_o, 8'h5A);

    // READ timeout, then STATUS
    do_read(8'h20, -1, 8'h00);
    wait_quiet();
    check("to_dur_lit", last_dur, 4);
    check("to_byte_lit", last_tx, 8'hFF);
    check("to_err_lit", err, 1);
    do_status();
    wait_quiet();
    check("st_byte_lit", last_tx, 8'h01);
    check("st_err_clr_lit", err, 0);

    // overrun while response is held back
    tx_ready = 1'b0;
    do_read(8'h20, 1, 8'h77);
    wait_tx_valid();
    send_byte(8'h55);
    ovr_m = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ovr_flag_lit", overrun, 1);
    check("ovr_tx_hold", tx_valid, 1);
    check("ovr_tx_data_lit", tx_data, 8'h77);
    tx_ready = 1'b1;
    wait_quiet();
    do_status();
    wait_quiet();
    check("ovr_status_lit", last_tx, 8'h02);

    // bad opcode then NOP
    send_byte(8'h7E);
    err_m = 1'b1;
    send_byte(8'h00);
    @(posedge clk); #1;
    check("bad_err_lit", err, 1);
    check("bad_state", dbg_state_o, ST_IDLE);
    check("bad_no_cyc", wbm_cyc_o, 0);
    wait_quiet();
    do_status();
    wait_quiet();
    // ack lands in the timeout cycle: data returned, err untouched
    do_read(8'h44, TO - 1, 8'hC3);
    wait_quiet();
    check("edge_dur_lit", last_dur, 4);
    check("edge_byte_lit", last_tx, 8'hC3);
    check("edge_err_lit", err, 0);

    // reset mid-BUS and mid-RESP
    do_read(8'h66, -1, 8'h00);
    async_reset();
    wait_quiet();
    tx_ready = 1'b0;
    do_read(8'h67, 0, 8'h99);
    wait_tx_valid();
    async_reset();
    tx_ready = 1'b1;
    wait_quiet();
    do_write(8'h12, 8'h34, 1);
    wait_quiet();
    do_read(8'h12, 0, 8'h5E);
    wait_quiet();
    check("post_rst_byte_lit", last_tx, 8'h5E);
    check("post_rst_adr_lit", wbm_adr_o, 8'h12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wbm_spi_ctrl.md
# wbm_spi_ctrl

Wishbone-domain command sequencer for the SPI-to-Wishbone bridge. It consumes bytes already imported from the SPI receive path (`rx_stb`/`rx_data`, one pulse per byte in `clk` domain) and parses them as opcode/address/data frames. It issues single classic Wishbone master cycles and hands read results to the SPI transmit path through a valid/ready byte handshake. It owns all protocol sequencing, the bus-timeout policy and the sticky error/overrun status.

## Interface
- `TIMEOUT`, default 255: max `clk` cycles a Wishbone cycle waits for `wbm_ack_i` before abort (1..65535).
- `ERR_BYTE`, default 8'hFF: byte returned for a timed-out read.

- `clk`  in  1  Wishbone clock; sole clock of the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_stb`  in  1  one-cycle pulse: `rx_data` holds a new received byte.
- `rx_data`  in  8  received byte.
- `tx_valid`  out  1  response byte available.
- `tx_ready`  in  1  SPI transmit side accepts byte when `tx_valid & tx_ready`.
- `tx_data`  out  8  response byte.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  Wishbone classic master controls.
- `wbm_adr_o`  out  8  address.
- `wbm_dat_o`  out  8  write data.
- `wbm_dat_i`  in  8  read data.
- `wbm_ack_i`  in  1  cycle acknowledge.
- `err`, `overrun`  out  1 each  sticky status flags.

## Operation
- Opcodes (first byte of a frame): 8'h00 NOP, 8'h01 READ, 8'h02 WRITE, 8'h03 STATUS; any other value is ignored, sets `err`, stays in IDLE.
- States: IDLE, ADDR, DATA, BUS, RESP.
- IDLE + `rx_stb`: NOP stays; READ/WRITE latch opcode and go to ADDR. STATUS loads `tx_data = {6'b0, overrun, err}`, clears both flags and goes to RESP.
- ADDR + `rx_stb`: latch `wbm_adr_o`. READ goes to BUS; WRITE goes to DATA.
- DATA + `rx_stb`: latch `wbm_dat_o`, go to BUS.
- BUS: `wbm_cyc_o = wbm_stb_o = 1`, `wbm_we_o` = (opcode == WRITE), held constant until exit.
  - `wbm_ack_i` on a READ: capture `wbm_dat_i` into `tx_data`, go to RESP.
  - `wbm_ack_i` on a WRITE: go to IDLE; no response byte.
- Timeout: counter clears on BUS entry and increments each BUS cycle. When it reaches `TIMEOUT` without ack, deassert cyc/stb, set `err`, and end the frame.
  - Timed-out READ loads `tx_data = ERR_BYTE` and goes to RESP.
  - Timed-out WRITE goes to IDLE.
- RESP: `tx_valid = 1` with `tx_data` stable; the transfer completes when `tx_ready` is high that cycle, then go to IDLE.
- `rx_stb` in BUS or RESP: byte dropped, `overrun` set, state unaffected.
- Flags clear only by reset or STATUS.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE; all outputs 0, including `tx_data`, `wbm_adr_o`, `wbm_dat_o`, `err`, `overrun`.
- `wbm_cyc_o`/`wbm_stb_o` rise the cycle after the `rx_stb` that completes the frame (address byte for READ, data byte for WRITE).
- Ack sampled at a clock edge: cyc/stb low the next cycle. READ sets `tx_valid` high that same next cycle.
- Zero-wait ack (ack in first BUS cycle) gives one-cycle bus cycle.
- Ack and timeout in the same cycle: ack wins, `err` untouched.
- STATUS: `tx_valid` rises the cycle after its `rx_stb`. The reported flags are values before clear. If overrun/err is set in the same cycle as the clear, set wins.
- `tx_ready` may be high before `tx_valid`; transfer occurs on the first cycle both are high. `tx_valid` drops the following cycle.
- Reset mid-BUS deasserts cyc/stb immediately (asynchronous); the in-flight frame is discarded.

## Structure
- Opcode constants, state encoding and status bit positions go in shared header `wbm_spi_defs.vh`. `wbm_spi_rx`/`wbm_spi_tx` companions use the same header.
- One sub-module: `wbm_spi_timeout` (clear/enable/expired counter, `TIMEOUT` parameter, width `$clog2(TIMEOUT+1)`). Everything else stays in one FSM module.

## Test plan
- READ: bytes 01, 3C, slave acks after 2 cycles with 8'hA5 -> one cycle, adr 3C, we 0, `tx_data` A5 presented once, `err` 0.
- WRITE: bytes 02, 10, 5A, zero-wait ack -> cyc/stb high exactly 1 cycle, adr 10, dat_o 5A, we 1, no `tx_valid`.
- Timeout, `TIMEOUT`=4, no ack: READ 01, 20 -> cyc drops after 4 BUS cycles, `tx_data` FF, `err` 1. Then STATUS 03 -> byte 01, `err` cleared.
- Overrun: send 01, 20, then an extra byte while `tx_ready`=0 -> `overrun` 1, response byte unchanged. STATUS -> byte 02.
- Bad opcode 7E then NOP 00 -> no bus cycle, `err` 1, state IDLE; next READ works normally.
- Reset asserted mid-BUS and mid-RESP -> cyc/stb/`tx_valid` low without a clock edge. Next frame completes correctly.
